// File: rtl/prbs_word_gen.sv
// prbs_word_gen: PRBS word generator with a selectable polynomial
// (PRBS7/15/23/31). Each generated word packs OUT_W consecutive sequence
// bits, first-generated bit at the MSB, behind a valid/ready handshake.
// Optional self-synchronising sequence checker, compiled in only when the
// macro PRBS_WORD_GEN_CHECKER_EN is defined; otherwise the checker ports
// stay present and the checker outputs read as zero.
module prbs_word_gen #(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [30:0]      seed,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             chk_valid,
    input  logic [OUT_W-1:0] chk_data,
    output logic             chk_lock,
    output logic [15:0]      err_cnt
);

    // Index of the top state bit (n-1) for the selected polynomial
    function automatic logic [4:0] top_idx(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd6;
            2'd1:    return 5'd14;
            2'd2:    return 5'd22;
            default: return 5'd30;
        endcase
    endfunction

    // Index of the second feedback tap (k-1) for the selected polynomial
    function automatic logic [4:0] tap_idx(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd5;
            2'd1:    return 5'd13;
            2'd2:    return 5'd17;
            default: return 5'd27;
        endcase
    endfunction

    // Mask covering the n live state bits of the selected polynomial
    function automatic logic [30:0] poly_mask(input logic [1:0] m);
        case (m)
            2'd0:    return 31'h0000007F;
            2'd1:    return 31'h00007FFF;
            2'd2:    return 31'h007FFFFF;
            default: return 31'h7FFFFFFF;
        endcase
    endfunction

    logic [1:0]       mode_q;
    logic [30:0]      s;
    logic [30:0]      s_next;
    logic [OUT_W-1:0] word_next;
    logic [30:0]      seed_masked;
    logic [30:0]      seed_load;
    logic             gen_word;

    // A new word is produced whenever enabled and the output slot is free or being emptied
    assign gen_word = en && (!out_valid || out_ready);

    // An all-zero seed would lock the LFSR, so it is replaced by all ones
    always_comb begin
        seed_masked = seed & poly_mask(mode);
        seed_load   = (seed_masked == 31'd0) ? poly_mask(mode) : seed_masked;
    end

    // Unroll OUT_W LFSR steps to build the next word and the advanced state
    always_comb begin : word_build
        logic [30:0]      st;
        logic [OUT_W-1:0] w;
        logic             fb;
        st = s;
        w  = '0;
        fb = 1'b0;
        for (int i = 0; i < OUT_W; i++) begin
            fb   = st[top_idx(mode_q)] ^ st[tap_idx(mode_q)];
            st   = ((st << 1) | {30'd0, fb}) & poly_mask(mode_q);
            w    = w << 1;
            w[0] = fb;
        end
        s_next    = st;
        word_next = w;
    end

    // State, mode and output register: reset beats load, load beats generation and handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= 2'd0;
            s         <= 31'h0000007F;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            mode_q    <= mode;
            s         <= seed_load;
            out_valid <= 1'b0;
        end else if (gen_word) begin
            s         <= s_next;
            out_data  <= word_next;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PRBS_WORD_GEN_CHECKER_EN

    logic [30:0] h;
    logic [30:0] h_next;
    logic [5:0]  word_err;
    logic [2:0]  clean_cnt;
    logic        lock_q;
    logic [15:0] err_q;
    logic [16:0] err_sum;

    // Predict each received bit from the history, count mismatches, shift received bits in
    always_comb begin : chk_word
        logic [30:0]      hv;
        logic [OUT_W-1:0] d;
        logic [5:0]       cnt;
        logic             b;
        hv  = h;
        d   = chk_data;
        cnt = 6'd0;
        b   = 1'b0;
        for (int i = 0; i < OUT_W; i++) begin
            b = d[OUT_W-1];
            d = d << 1;
            if (b != (hv[top_idx(mode_q)] ^ hv[tap_idx(mode_q)])) begin
                cnt = cnt + 6'd1;
            end
            hv = {hv[29:0], b};
        end
        h_next   = hv;
        word_err = cnt;
        err_sum  = {1'b0, err_q} + {11'd0, word_err};
    end

    // Lock after four clean words; count errors only while locked, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            h         <= '0;
            clean_cnt <= 3'd0;
            lock_q    <= 1'b0;
            err_q     <= 16'd0;
        end else if (load) begin
            h         <= '0;
            clean_cnt <= 3'd0;
            lock_q    <= 1'b0;
        end else if (chk_valid) begin
            h <= h_next;
            if (lock_q) begin
                err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            end else if (word_err == 6'd0) begin
                if (clean_cnt == 3'd3) begin
                    lock_q <= 1'b1;
                end else begin
                    clean_cnt <= clean_cnt + 3'd1;
                end
            end else begin
                clean_cnt <= 3'd0;
            end
        end
    end

    assign chk_lock = lock_q;
    assign err_cnt  = err_q;

`else

    logic chk_unused;

    // Checker inputs are deliberately ignored when the checker is not built
    assign chk_unused = ^{chk_valid, chk_data};
    assign chk_lock   = 1'b0;
    assign err_cnt    = 16'd0;

`endif

endmodule

// File: tb/tb_prbs_word_gen.sv
// tb_prbs_word_gen: directed, table-driven bench for prbs_word_gen with
// hand-computed PRBS words plus a small reference model for longer runs.
// Checker section is compiled when PRBS_WORD_GEN_CHECKER_EN is defined.
module tb_prbs_word_gen;

    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic             load;
    logic [30:0]      seed;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             chk_valid;
    logic [OUT_W-1:0] chk_data;
    logic             chk_lock;
    logic [15:0]      err_cnt;

    logic             loopback;
    logic [OUT_W-1:0] flip;
    logic             chk_valid_m;
    logic [OUT_W-1:0] chk_data_m;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string       name;
        logic        en;
        logic        rdy;
        logic        ld;
        logic [1:0]  mode;
        logic [30:0] seed;
        logic        exp_valid;
        logic        cmp_data;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t tbl[14];

    always #5 clk = ~clk;

    assign chk_valid = loopback ? (out_valid & out_ready) : chk_valid_m;
    assign chk_data  = loopback ? (out_data ^ flip) : chk_data_m;

    prbs_word_gen #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .load      (load),
        .seed      (seed),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .chk_valid (chk_valid),
        .chk_data  (chk_data),
        .chk_lock  (chk_lock),
        .err_cnt   (err_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic r, input logic l,
                                 input logic [1:0] m, input logic [30:0] sd);
        en        = e;
        out_ready = r;
        load      = l;
        mode      = m;
        seed      = sd;
        chk_data_m = OUT_W'($urandom);
        @(posedge clk);
        #1;
`ifndef PRBS_WORD_GEN_CHECKER_EN
        checkOutput("chk_lock_off", {31'd0, chk_lock}, 32'd0);
        checkOutput("err_cnt_off", {16'd0, err_cnt}, 32'd0);
`endif
    endtask

    task automatic modelWord(input int n, input int k, inout logic [30:0] st, output logic [7:0] w);
        logic        fb;
        logic [30:0] mask;
        mask = (n == 31) ? 31'h7FFFFFFF : ((31'd1 << n) - 31'd1);
        w = '0;
        for (int i = 0; i < 8; i++) begin
            fb = st[n-1] ^ st[k-1];
            st = ((st << 1) | {30'd0, fb}) & mask;
            w  = {w[6:0], fb};
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [30:0] ms;
        logic [7:0]  w;
        logic [7:0]  held;
        logic [7:0]  p31_hand[4];

        tbl[0]  = '{"w1",            1'b1, 1'b1, 1'b0, 2'd0, 31'd0,          1'b1, 1'b1, 8'h02};
        tbl[1]  = '{"stall",         1'b1, 1'b0, 1'b0, 2'd0, 31'd0,          1'b1, 1'b1, 8'h02};
        tbl[2]  = '{"stall_en0",     1'b0, 1'b0, 1'b0, 2'd0, 31'd0,          1'b1, 1'b1, 8'h02};
        tbl[3]  = '{"accept_idle",   1'b0, 1'b1, 1'b0, 2'd0, 31'd0,          1'b0, 1'b0, 8'h00};
        tbl[4]  = '{"gen_from_idle", 1'b1, 1'b0, 1'b0, 2'd0, 31'd0,          1'b1, 1'b1, 8'h0C};
        tbl[5]  = '{"w3",            1'b1, 1'b1, 1'b0, 2'd0, 31'd0,          1'b1, 1'b1, 8'h28};
        tbl[6]  = '{"load_seed0",    1'b1, 1'b1, 1'b1, 2'd0, 31'd0,          1'b0, 1'b0, 8'h00};
        tbl[7]  = '{"seed0_ones",    1'b1, 1'b1, 1'b0, 2'd0, 31'd0,          1'b1, 1'b1, 8'h02};
        tbl[8]  = '{"load_hibits",   1'b0, 1'b1, 1'b1, 2'd0, 31'h7ABCDEFF,   1'b0, 1'b0, 8'h00};
        tbl[9]  = '{"hibits_ignored",1'b1, 1'b1, 1'b0, 2'd0, 31'd0,          1'b1, 1'b1, 8'h02};
        tbl[10] = '{"load_seed02",   1'b1, 1'b0, 1'b1, 2'd0, 31'h00000002,   1'b0, 1'b0, 8'h00};
        tbl[11] = '{"seed02_word",   1'b1, 1'b1, 1'b0, 2'd0, 31'd0,          1'b1, 1'b1, 8'h0C};
        tbl[12] = '{"accept_en0",    1'b0, 1'b1, 1'b0, 2'd0, 31'd0,          1'b0, 1'b0, 8'h00};
        tbl[13] = '{"resume",        1'b1, 1'b0, 1'b0, 2'd0, 31'd0,          1'b1, 1'b1, 8'h28};

        p31_hand[0] = 8'h00;
        p31_hand[1] = 8'h00;
        p31_hand[2] = 8'h00;
        p31_hand[3] = 8'h0E;

        loopback    = 1'b0;
        flip        = '0;
        chk_valid_m = 1'b1;
        chk_data_m  = '0;
        reset       = 1'b1;

        // Reset state
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 31'd5);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
        checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_data", {24'd0, out_data}, 32'd0);
        checkOutput("reset_state", {1'b0, dut.s}, 32'h7F);

        // Table-driven handshake and load vectors
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i].en, tbl[i].rdy, tbl[i].ld, tbl[i].mode, tbl[i].seed);
            checkOutput({tbl[i].name, "_valid"}, {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
            if (tbl[i].cmp_data) begin
                checkOutput({tbl[i].name, "_data"}, {24'd0, out_data}, {24'd0, tbl[i].exp_data});
            end
        end

        // Full-period run after reset: valid rises one cycle after reset falls
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
        checkOutput("rst2_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        ms = 31'h7F;
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
        modelWord(7, 6, ms, w);
        checkOutput("first_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("first_word", {24'd0, out_data}, 32'h02);
        for (int i = 2; i <= 128; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
            modelWord(7, 6, ms, w);
            if (i == 127) checkOutput("word127_model", {24'd0, out_data}, {24'd0, w});
            if (i == 128) checkOutput("word128", {24'd0, out_data}, 32'h02);
        end

        // Five-cycle stall holds the word; next word only after acceptance
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 31'd0);
            checkOutput("stall5_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stall5_data", {24'd0, out_data}, {24'd0, held});
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
        modelWord(7, 6, ms, w);
        checkOutput("after_stall", {24'd0, out_data}, {24'd0, w});

        // PRBS31 with zero seed becomes all ones
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 31'd0);
        checkOutput("p31_load_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("p31_state", {1'b0, dut.s}, 32'h7FFFFFFF);
        ms = 31'h7FFFFFFF;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
            modelWord(31, 28, ms, w);
            checkOutput("p31_model", {24'd0, out_data}, {24'd0, w});
            if (i < 4) checkOutput("p31_hand", {24'd0, out_data}, {24'd0, p31_hand[i]});
        end

        // PRBS15 and PRBS23 with upper seed bits set
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 31'h7FFF1234);
        checkOutput("p15_state", {1'b0, dut.s}, 32'h1234);
        ms = 31'h1234;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
            modelWord(15, 14, ms, w);
            checkOutput("p15_model", {24'd0, out_data}, {24'd0, w});
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 31'h04ABCDEF);
        checkOutput("p23_state", {1'b0, dut.s}, 32'h2BCDEF);
        ms = 31'h2BCDEF;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
            modelWord(23, 18, ms, w);
            checkOutput("p23_model", {24'd0, out_data}, {24'd0, w});
        end

        // Reset mid-handshake discards the word and beats a simultaneous load
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 31'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 31'd0);
        checkOutput("pend_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 31'd9);
        checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_data", {24'd0, out_data}, 32'd0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
        checkOutput("midrst_word", {24'd0, out_data}, 32'h02);

`ifdef PRBS_WORD_GEN_CHECKER_EN
        begin
            logic [30:0] hm;
            logic        e;
            logic        b;
            int          waited;

            // Loopback on PRBS15: lock, then one flipped bit costs three mismatches
            loopback = 1'b1;
            applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 31'h00000ACE);
            waited = 0;
            while (!chk_lock && waited < 40) begin
                applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
                waited++;
            end
            checkOutput("lock_reached", {31'd0, chk_lock}, 32'd1);
            for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
            checkOutput("loop_clean", {16'd0, err_cnt}, 32'd0);
            flip = 8'h10;
            applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
            flip = 8'h00;
            for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 31'd0);
            checkOutput("flip_err3", {16'd0, err_cnt}, 32'd3);

            // Fresh count, then all-error words until err_cnt saturates
            loopback = 1'b0;
            reset = 1'b1;
            chk_valid_m = 1'b0;
            applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 31'd0);
            reset = 1'b0;
            applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 31'd1);
            checkOutput("sat_start_lock", {31'd0, chk_lock}, 32'd0);
            hm = '0;
            chk_valid_m = 1'b1;
            for (int i = 0; i < 4; i++) begin
                en = 1'b0; out_ready = 1'b1; load = 1'b0;
                chk_data_m = 8'h00;
                @(posedge clk);
                #1;
            end
            checkOutput("sat_lock", {31'd0, chk_lock}, 32'd1);
            for (int wd = 1; wd <= 8210; wd++) begin
                for (int j = 0; j < 8; j++) begin
                    e  = hm[14] ^ hm[13];
                    b  = ~e;
                    hm = {hm[29:0], b};
                    chk_data_m = {chk_data_m[6:0], b};
                end
                @(posedge clk);
                #1;
                if (wd == 100)  checkOutput("err_800", {16'd0, err_cnt}, 32'd800);
                if (wd == 8200) checkOutput("err_sat", {16'd0, err_cnt}, 32'hFFFF);
            end
            checkOutput("err_no_wrap", {16'd0, err_cnt}, 32'hFFFF);
            chk_valid_m = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/prbs_word_gen.md
PRBS_WORD_GEN -- requirements
Module: prbs_word_gen

Interface
REQ-001 SHALL have parameter OUT_W, 8, bits per output word (1..32).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  generation enable.
REQ-005 SHALL have port mode  input  2  polynomial select, sampled on load only: 0=PRBS7 (x^7+x^6+1), 1=PRBS15 (x^15+x^14+1), 2=PRBS23 (x^23+x^18+1), 3=PRBS31 (x^31+x^28+1).
REQ-006 SHALL have port load  input  1  seed/mode load strobe.
REQ-007 SHALL have port seed  input  31  seed value; only low n bits used for PRBS-n.
REQ-008 SHALL have port out_data  output  OUT_W  generated word, first-generated bit at MSB.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts word when out_valid and out_ready are both high.
REQ-011 SHALL have ports chk_valid input 1, chk_data input OUT_W, chk_lock output 1, err_cnt output 16 (checker, see Configuration).

Function
REQ-012 SHALL hold a 31-bit state s and a registered mode_q; for PRBS-n with tap k, each step computes fb = s[n-1] XOR s[k-1], sets s[n-1:0] = {s[n-2:0], fb}, keeps s[30:n] at 0, and emits fb.
REQ-013 SHALL perform exactly OUT_W steps per generated word within one cycle; step 1 bit lands in out_data[OUT_W-1], step OUT_W bit in out_data[0].
REQ-014 SHALL generate a new word at a clock edge when en=1 and (out_valid=0 or out_ready=1), setting out_valid=1 on that edge (1-cycle latency).
REQ-015 SHALL hold out_data, out_valid and s unchanged while out_valid=1 and out_ready=0, regardless of en.
REQ-016 SHALL clear out_valid at an edge where a word is accepted and en=0.
REQ-017 SHALL on load=1: set mode_q=mode, s[n-1:0]=seed[n-1:0], clear out_valid; no word is generated that cycle; load has priority over generation and handshake.
REQ-018 SHALL substitute all-ones (low n bits) when the loaded seed's low n bits are all zero (lock-up prevention).
REQ-019 SHALL return to the same state after 2^n-1 steps (maximal-length sequence).

Reset
REQ-020 SHALL on reset=1 set mode_q=0 (PRBS7), s=31'h0000007F, out_valid=0, out_data=0, chk_lock=0, err_cnt=0; reset has priority over load.
REQ-021 SHALL accept reset asserted mid-handshake; the pending word is discarded with no acceptance.

Configuration
REQ-022 SHALL compile the checker only when macro PRBS_WORD_GEN_CHECKER_EN is defined.
REQ-023 SHALL, with the macro, run a self-synchronising checker: 31-bit history h; per received bit b (MSB first) on chk_valid=1, expected = h[n-1] XOR h[k-1] using mode_q, mismatch if b differs, then b is shifted into h.
REQ-024 SHALL, with the macro, set chk_lock after 4 consecutive mismatch-free chk_valid words; clear chk_lock and h on reset or load.
REQ-025 SHALL, with the macro, add the word's mismatch count to err_cnt only while chk_lock=1 at the cycle the word is received, saturating at 16'hFFFF.
REQ-026 SHALL, without the macro, keep all ports present, ignore chk_valid/chk_data, and drive chk_lock=0, err_cnt=0.

Verification
REQ-027 Reset, then en=1, out_ready=1, OUT_W=8 -> out_valid rises one cycle after reset falls; first word 8'h02; word 128 again 8'h02.
REQ-028 out_ready=0 for 5 cycles with out_valid=1 -> out_data and out_valid stable; next word follows only after acceptance.
REQ-029 load=1, mode=3, seed=0 -> out_valid=0 next cycle; state equals 31'h7FFFFFFF; subsequent words match PRBS31 reference model.
REQ-030 Loopback out_data to chk_data (macro on), mode 1 -> chk_lock after 4 words, err_cnt=0; flip one bit in one word -> err_cnt increments (1 in that word, plus propagated mismatches of tap feedback: 3 total for PRBS15).
REQ-031 Force 70000 all-error words while locked -> err_cnt saturates at 16'hFFFF, no wrap.
REQ-032 Reset asserted while out_valid=1, out_ready=0 -> out_valid=0, out_data=0 next edge; macro off -> chk_lock=0, err_cnt=0 at all times.
